tri_edge_sequencer: RTL and testbench

- Upstream control stage for the Bresenham line drawer: accepts one triangle (three 10-bit screen-space vertices) and issues its three wireframe edges to the drawer, one after another.
- Edge order: v0->v1, v1->v2, v2->v0.
- Owns the drawer's load pulse and start/done level handshake. Qualifies the drawer's DrawX/DrawY with a plot enable for the framebuffer writer.
- Watchdog aborts the triangle if the drawer never reports done.

---
 rtl/tri_edge_sequencer.sv | 154 +++++++++++++++
 tb/tb_tri_edge_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tri_edge_sequencer.sv
// Issues a triangle's three wireframe edges (v0->v1, v1->v2, v2->v0) to a Bresenham drawer.
// Per edge: LOAD 1 cycle, START until drawer done or watchdog abort, RELEASE until done drops.
module tri_edge_sequencer #(
  parameter int COORD_W = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               tri_Start,
  input  logic [COORD_W-1:0] vx0,
  input  logic [COORD_W-1:0] vy0,
  input  logic [COORD_W-1:0] vx1,
  input  logic [COORD_W-1:0] vy1,
  input  logic [COORD_W-1:0] vx2,
  input  logic [COORD_W-1:0] vy2,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1,
  output logic               line_Load,
  output logic               draw_line_Start,
  input  logic               draw_line_Done,
  output logic               plot_En,
  output logic [1:0]         edge_Idx,
  output logic               tri_Busy,
  output logic               tri_Done,
  output logic               tri_Err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RELEASE,
    S_FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         edge_q, edge_nxt;
  logic [CNT_W-1:0]   wd_q, wd_nxt;
  logic               err_q, err_nxt;
  logic               capture;
  logic [COORD_W-1:0] lx0, ly0, lx1, ly1, lx2, ly2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      edge_q <= 2'd0;
      wd_q   <= '0;
      err_q  <= 1'b0;
      lx0    <= '0;
      ly0    <= '0;
      lx1    <= '0;
      ly1    <= '0;
      lx2    <= '0;
      ly2    <= '0;
    end else begin
      state  <= state_nxt;
      edge_q <= edge_nxt;
      wd_q   <= wd_nxt;
      err_q  <= err_nxt;
      if (capture) begin
        lx0 <= vx0;
        ly0 <= vy0;
        lx1 <= vx1;
        ly1 <= vy1;
        lx2 <= vx2;
        ly2 <= vy2;
      end
    end
  end

  // err_q is cleared on acceptance, so within a triangle it doubles as the abort mark.
  always_comb begin
    state_nxt = state;
    edge_nxt  = edge_q;
    wd_nxt    = wd_q;
    err_nxt   = err_q;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tri_Start) begin
          capture   = 1'b1;
          err_nxt   = 1'b0;
          edge_nxt  = 2'd0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        wd_nxt    = '0;
        state_nxt = S_START;
      end
      S_START: begin
        if (draw_line_Done) begin
          state_nxt = S_RELEASE;
        end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          wd_nxt = wd_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!draw_line_Done) begin
          if (err_q) begin
            state_nxt = S_FINISH;
          end else if (edge_q != 2'd2) begin
            edge_nxt  = edge_q + 2'd1;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (!tri_Start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    line_x0 = lx0;
    line_y0 = ly0;
    line_x1 = lx1;
    line_y1 = ly1;
    case (edge_q)
      2'd1: begin
        line_x0 = lx1;
        line_y0 = ly1;
        line_x1 = lx2;
        line_y1 = ly2;
      end
      2'd2: begin
        line_x0 = lx2;
        line_y0 = ly2;
        line_x1 = lx0;
        line_y1 = ly0;
      end
      default: ;
    endcase
  end

  assign line_Load       = (state == S_LOAD);
  assign draw_line_Start = (state == S_START);
  assign plot_En         = (state == S_START);
  assign edge_Idx        = edge_q;
  assign tri_Busy        = (state == S_LOAD) || (state == S_START) || (state == S_RELEASE);
  assign tri_Done        = (state == S_FINISH);
  assign tri_Err         = err_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Directed bench for tri_edge_sequencer with a behavioural drawer model and load monitor.
module tb_tri_edge_sequencer;

  localparam int TIMEOUT = 4096;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       tri_Start = 1'b0;
  logic [9:0] vx0 = '0, vy0 = '0, vx1 = '0, vy1 = '0, vx2 = '0, vy2 = '0;
  logic [9:0] line_x0, line_y0, line_x1, line_y1;
  logic       line_Load, draw_line_Start, plot_En, tri_Busy, tri_Done, tri_Err;
  logic       draw_line_Done = 1'b0;
  logic [1:0] edge_Idx;

  tri_edge_sequencer #(.COORD_W(10), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .tri_Start(tri_Start),
    .vx0(vx0), .vy0(vy0), .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_Load(line_Load), .draw_line_Start(draw_line_Start),
    .draw_line_Done(draw_line_Done), .plot_En(plot_En), .edge_Idx(edge_Idx),
    .tri_Busy(tri_Busy), .tri_Done(tri_Done), .tri_Err(tri_Err)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'd0, line_x0, line_y0, line_x1, line_y1, line_Load, draw_line_Start,
            plot_En, edge_Idx, tri_Busy, tri_Done, tri_Err};
  endfunction

  // Drawer model: START lasts (max(|dx|,|dy|) + 1) cycles; done drops two cycles after start falls.
  int d_len, d_cnt, hang_edge = 3;
  bit lag;
  always @(negedge Clk) begin
    int dx, dy;
    if (!Reset_n) begin
      draw_line_Done = 1'b0; d_cnt = 0; lag = 1'b0;
    end else if (line_Load) begin
      dx = int'(line_x1) - int'(line_x0);
      dy = int'(line_y1) - int'(line_y0);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      d_len = (dx > dy) ? dx : dy;
      d_cnt = 0; draw_line_Done = 1'b0; lag = 1'b0;
    end else if (draw_line_Start) begin
      if (!draw_line_Done && int'(edge_Idx) != hang_edge) begin
        if (d_cnt >= d_len) draw_line_Done = 1'b1;
        else d_cnt++;
      end
    end else if (draw_line_Done) begin
      if (lag) begin draw_line_Done = 1'b0; lag = 1'b0; end
      else lag = 1'b1;
    end
  end

  // Monitor: records every load and counts START cycles and endpoint hold violations.
  int          n_load = 0;
  int          hold_viol = 0;
  logic [39:0] rec_e [64];
  logic [1:0]  rec_i [64];
  logic        rec_err [64];
  int          scyc [64];
  logic [39:0] cur = '0;
  always @(negedge Clk) begin
    if (line_Load && n_load < 64) begin
      cur = {line_x0, line_y0, line_x1, line_y1};
      rec_e[n_load] = cur;
      rec_i[n_load] = edge_Idx;
      rec_err[n_load] = tri_Err;
      scyc[n_load] = 0;
      n_load++;
    end else if (tri_Busy && {line_x0, line_y0, line_x1, line_y1} !== cur) begin
      hold_viol++;
    end
    if (draw_line_Start && n_load > 0) scyc[n_load-1]++;
  end

  typedef struct packed {
    logic [5:0][9:0]  v;
    logic [1:0]       hang;
    logic [2:0]       nl;
    logic             err;
    logic [2:0][39:0] e;
    logic [2:0][12:0] sc;
  } vec_t;

  function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2, hang, nl, err,
                              input logic [39:0] e0, e1, e2, input int s0, s1, s2);
    vec_t r;
    r.v[0] = 10'(x0); r.v[1] = 10'(y0); r.v[2] = 10'(x1);
    r.v[3] = 10'(y1); r.v[4] = 10'(x2); r.v[5] = 10'(y2);
    r.hang = 2'(hang); r.nl = 3'(nl); r.err = 1'(err);
    r.e[0] = e0; r.e[1] = e1; r.e[2] = e2;
    r.sc[0] = 13'(s0); r.sc[1] = 13'(s1); r.sc[2] = 13'(s2);
    return r;
  endfunction

  task automatic wait_for(input string name, input bit want_done, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk);
      if (want_done) got = tri_Done;
      else got = draw_line_Start;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic run_vec(input int r, input vec_t t);
    int base, viol0;
    @(negedge Clk);
    vx0 = t.v[0]; vy0 = t.v[1]; vx1 = t.v[2]; vy1 = t.v[3]; vx2 = t.v[4]; vy2 = t.v[5];
    hang_edge = (t.hang == 2'd3) ? 3 : int'(t.hang);
    base = n_load; viol0 = hold_viol;
    tri_Start = 1'b1;
    wait_for($sformatf("r%0d_done_reached", r), 1'b1, 20000);
    chk($sformatf("r%0d_loads", r), 64'(n_load - base), 64'(t.nl));
    for (int k = 0; k < int'(t.nl); k++) begin
      chk($sformatf("r%0d_edge%0d_pts", r, k), 64'(rec_e[base+k]), 64'(t.e[k]));
      chk($sformatf("r%0d_edge%0d_idx", r, k), 64'(rec_i[base+k]), 64'(k));
      chk($sformatf("r%0d_edge%0d_errclr", r, k), 64'(rec_err[base+k]), 64'd0);
      chk($sformatf("r%0d_edge%0d_startcyc", r, k), 64'(scyc[base+k]), 64'(t.sc[k]));
    end
    chk($sformatf("r%0d_err", r), 64'(tri_Err), 64'(t.err));
    chk($sformatf("r%0d_hold", r), 64'(hold_viol - viol0), 64'd0);
    repeat (4) @(negedge Clk);
    chk($sformatf("r%0d_finish_held", r), 64'({tri_Done, tri_Busy, line_Load}), 64'b100);
    chk($sformatf("r%0d_no_retrigger", r), 64'(n_load - base), 64'(t.nl));
    chk($sformatf("r%0d_idx_hold", r), 64'(edge_Idx), 64'(t.nl - 3'd1));
    chk($sformatf("r%0d_pts_hold", r), 64'({line_x0, line_y0, line_x1, line_y1}),
        64'(t.e[t.nl - 3'd1]));
    tri_Start = 1'b0;
    @(negedge Clk);
    chk($sformatf("r%0d_back_idle", r), 64'({tri_Done, tri_Busy}), 64'd0);
    hang_edge = 3;
  endtask

  vec_t vecs [4];

  initial begin
    int base;
    vecs[0] = mk(10, 10, 20, 10, 10, 20, 3, 3, 0,
                 {10'd10, 10'd10, 10'd20, 10'd10}, {10'd20, 10'd10, 10'd10, 10'd20},
                 {10'd10, 10'd20, 10'd10, 10'd10}, 11, 11, 11);
    vecs[1] = mk(5, 5, 5, 5, 5, 5, 3, 3, 0,
                 {10'd5, 10'd5, 10'd5, 10'd5}, {10'd5, 10'd5, 10'd5, 10'd5},
                 {10'd5, 10'd5, 10'd5, 10'd5}, 1, 1, 1);
    vecs[2] = mk(10, 10, 20, 10, 10, 20, 1, 2, 1,
                 {10'd10, 10'd10, 10'd20, 10'd10}, {10'd20, 10'd10, 10'd10, 10'd20},
                 40'd0, 11, TIMEOUT, 0);
    vecs[3] = mk(100, 200, 300, 50, 7, 7, 3, 3, 0,
                 {10'd100, 10'd200, 10'd300, 10'd50}, {10'd300, 10'd50, 10'd7, 10'd7},
                 {10'd7, 10'd7, 10'd100, 10'd200}, 201, 294, 194);

    #2;
    chk("reset_outputs", all_outs(), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_without_start", all_outs(), 64'd0);

    for (int r = 0; r < 4; r++) run_vec(r, vecs[r]);

    // Asynchronous reset in the middle of edge 1.
    @(negedge Clk);
    vx0 = 10'd10; vy0 = 10'd10; vx1 = 10'd20; vy1 = 10'd10; vx2 = 10'd10; vy2 = 10'd20;
    tri_Start = 1'b1;
    for (int i = 0; i < 200 && !(draw_line_Start && edge_Idx == 2'd1); i++) @(negedge Clk);
    chk("rst_reached_edge1", 64'({draw_line_Start, edge_Idx}), 64'b101);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 chk("rst_async_outputs", all_outs(), 64'd0);
    tri_Start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    base = n_load;
    repeat (6) @(negedge Clk);
    chk("rst_stays_idle", 64'({tri_Busy, tri_Done, line_Load}), 64'd0);
    chk("rst_no_load", 64'(n_load - base), 64'd0);

    // Vertices scrambled and request dropped during edge 0.
    vx0 = 10'd1; vy0 = 10'd2; vx1 = 10'd3; vy1 = 10'd4; vx2 = 10'd5; vy2 = 10'd6;
    tri_Start = 1'b1;
    wait_for("chg_start_seen", 1'b0, 50);
    chk("chg_on_edge0", 64'(edge_Idx), 64'd0);
    vx0 = 10'd999; vy0 = 10'd999; vx1 = 10'd999; vy1 = 10'd999; vx2 = 10'd999; vy2 = 10'd999;
    tri_Start = 1'b0;
    wait_for("chg_done_reached", 1'b1, 200);
    chk("chg_loads", 64'(n_load - base), 64'd3);
    chk("chg_edge1", 64'(rec_e[base+1]), 64'({10'd3, 10'd4, 10'd5, 10'd6}));
    chk("chg_edge2", 64'(rec_e[base+2]), 64'({10'd5, 10'd6, 10'd1, 10'd2}));
    chk("chg_err", 64'(tri_Err), 64'd0);
    @(negedge Clk);
    chk("chg_back_idle", 64'({tri_Done, tri_Busy}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
